// File: rtl/ucie_ctl_tx_gearbox.sv
// UCIe TX gearbox: queues FDI flits and serialises each one LSB chunk first onto the narrower RDI bus.
// Registered RDI output; holds while RDI trdy is low; FDI trdy low when not ACTIVE or FIFO full. Macro: UCIE_TX_OCCUPANCY_EN.
module ucie_ctl_tx_gearbox #(
    parameter int         FDI_WIDTH   = 256,
    parameter int         RATIO       = 4,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [3:0] UCIE_ACTIVE = 4'b0001,
    localparam int        RDI_WIDTH   = FDI_WIDTH / RATIO
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [3:0]                   i_fdi_pl_state_sts,
    input  logic                         i_fdi_lp_valid,
    input  logic                         i_fdi_lp_irdy,
    input  logic [FDI_WIDTH-1:0]         i_w_data,
    output logic                         o_fdi_pl_trdy,
    output logic                         o_tx_overf_err,
    output logic                         o_rdi_lp_valid,
    output logic                         o_rdi_lp_irdy,
    input  logic                         i_rdi_pl_trdy,
    output logic [RDI_WIDTH-1:0]         o_r_data
`ifdef UCIE_TX_OCCUPANCY_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0]  o_tx_occupancy
`endif
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [AW:0]   PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt, sel_ptr;
    logic [CW-1:0]        cnt_q, cnt_d, sel_cnt;
    logic                 vld_q, vld_d, ovf_q, ovf_d;
    logic [RDI_WIDTH-1:0] rdat_q, rdat_d;
    logic [FDI_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                 full, empty, push, xfer, last_chunk, flush_sts, is_active, run;

    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign o_fdi_pl_trdy = (state_q == ACTIVE) && !full;
    assign push          = i_fdi_lp_valid && i_fdi_lp_irdy && o_fdi_pl_trdy;
    assign xfer          = vld_q && i_rdi_pl_trdy;
    assign last_chunk    = (cnt_q == LAST_CNT);
    assign is_active     = (i_fdi_pl_state_sts == UCIE_ACTIVE);
    assign flush_sts     = (i_fdi_pl_state_sts == 4'b1001) || (i_fdi_pl_state_sts == 4'b1010) ||
                           (i_fdi_pl_state_sts == 4'b1100);

    assign o_rdi_lp_valid = vld_q;
    assign o_rdi_lp_irdy  = vld_q;
    assign o_r_data       = rdat_q;
    assign o_tx_overf_err = ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_active) state_d = ACTIVE;
            ACTIVE:  if (flush_sts) state_d = FLUSH;
                     else if (!is_active) state_d = DRAIN;
            DRAIN:   if (flush_sts) state_d = FLUSH;
                     else if (is_active) state_d = ACTIVE;
                     else if (empty && !vld_q) state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run      = ((state_q == ACTIVE) || (state_q == DRAIN)) && (state_d != FLUSH);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q;
        rd_nxt   = rd_ptr_q + PTR_ONE;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        rdat_d   = rdat_q;
        sel_ptr  = rd_ptr_q;
        sel_cnt  = cnt_q;
        ovf_d    = i_fdi_lp_valid && i_fdi_lp_irdy && (state_q != ACTIVE);
        if (xfer) begin
            if (last_chunk) begin
                rd_ptr_d = rd_nxt;
                cnt_d    = '0;
                sel_ptr  = rd_nxt;
                sel_cnt  = '0;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                sel_cnt = cnt_d;
            end
        end
        // The next head entry is readable only if it was written before this cycle.
        if (run) begin
            if (xfer) begin
                vld_d = !(last_chunk && (rd_nxt == wr_ptr_q));
            end else if (!vld_q) begin
                vld_d = !empty;
            end
            if (vld_d && (xfer || !vld_q)) begin
                rdat_d = mem_q[sel_ptr[AW-1:0]][int'(sel_cnt)*RDI_WIDTH +: RDI_WIDTH];
            end
        end else begin
            vld_d = 1'b0;
        end
        if (state_q == FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            rdat_q   <= rdat_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_w_data;
        end
    end

`ifdef UCIE_TX_OCCUPANCY_EN
    logic [AW:0] occ_q;
    assign o_tx_occupancy = occ_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= wr_ptr_d - rd_ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_ucie_ctl_tx_gearbox.sv
// Directed bench for ucie_ctl_tx_gearbox at FDI_WIDTH=64, RATIO=4, FIFO_DEPTH=4.
module tb_ucie_ctl_tx_gearbox;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sts;
    logic        lp_valid, lp_irdy, rdi_trdy;
    logic [63:0] w_data;
    logic        fdi_trdy, overf, rdi_valid, rdi_irdy;
    logic [15:0] r_data;
`ifdef UCIE_TX_OCCUPANCY_EN
    logic [2:0]  occ;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  s;
        logic        v;
        logic        ir;
        logic [63:0] d;
        logic        rt;
        logic        etrdy;
        logic        eovf;
        logic        evld;
        logic [15:0] edat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ucie_ctl_tx_gearbox #(.FDI_WIDTH(64), .RATIO(4), .FIFO_DEPTH(4)) dut (
        .i_clk              (clk),
        .i_rst              (rst_n),
        .i_fdi_pl_state_sts (sts),
        .i_fdi_lp_valid     (lp_valid),
        .i_fdi_lp_irdy      (lp_irdy),
        .i_w_data           (w_data),
        .o_fdi_pl_trdy      (fdi_trdy),
        .o_tx_overf_err     (overf),
        .o_rdi_lp_valid     (rdi_valid),
        .o_rdi_lp_irdy      (rdi_irdy),
        .i_rdi_pl_trdy      (rdi_trdy),
        .o_r_data           (r_data)
`ifdef UCIE_TX_OCCUPANCY_EN
        ,
        .o_tx_occupancy     (occ)
`endif
    );

    function automatic logic [15:0] ck(input int k, input int c);
        ck = {4'hE, 4'(k), 4'h0, 4'(c)};
    endfunction

    function automatic logic [63:0] entry(input int k);
        entry = {ck(k, 3), ck(k, 2), ck(k, 1), ck(k, 0)};
    endfunction

    function automatic void add(input logic [3:0] s, input logic v, input logic ir, input logic [63:0] d,
                                input logic rt, input logic et, input logic eo, input logic ev,
                                input logic [15:0] ed);
        vec_t r;
        r.s = s; r.v = v; r.ir = ir; r.d = d; r.rt = rt;
        r.etrdy = et; r.eovf = eo; r.evld = ev; r.edat = ed;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic v, input logic ir, input logic [63:0] d,
                         input logic rt);
        @(negedge clk);
        sts = s; lp_valid = v; lp_irdy = ir; w_data = d; rdi_trdy = rt;
        #1;
    endtask

    initial begin
        int got;
        sts = 4'b0000; lp_valid = 0; lp_irdy = 0; w_data = '0; rdi_trdy = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset trdy", fdi_trdy, 0);
        chk("reset ovf", overf, 0);
        chk("reset rvld", rdi_valid, 0);
        chk("reset rirdy", rdi_irdy, 0);
        chk("reset rdata", r_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single flit, full-rate RDI
        add(4'h1, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0);
        add(4'h1, 1, 1, 64'h4444_3333_2222_1111, 0, 1, 0, 0, 16'h0);
        add(4'h1, 0, 0, 64'h0, 1, 1, 0, 0, 16'h0);
        add(4'h1, 0, 0, 64'h0, 1, 1, 0, 1, 16'h1111);
        add(4'h1, 0, 0, 64'h0, 1, 1, 0, 1, 16'h2222);
        add(4'h1, 0, 0, 64'h0, 1, 1, 0, 1, 16'h3333);
        add(4'h1, 0, 0, 64'h0, 1, 1, 0, 1, 16'h4444);
        add(4'h1, 0, 0, 64'h0, 0, 1, 0, 0, 16'h0);
        // Backpressure: four fill the FIFO, fifth is refused without error
        for (int k = 0; k < 4; k++) add(4'h1, 1, 1, entry(k), 0, 1, 0, (k >= 2), ck(0, 0));
        add(4'h1, 1, 1, entry(4), 0, 0, 0, 1, ck(0, 0));
        for (int i = 0; i < 16; i++) add(4'h1, 0, 0, 64'h0, 1, (i >= 4), 0, 1, ck(i / 4, i % 4));
        add(4'h1, 0, 0, 64'h0, 0, 1, 0, 0, 16'h0);
        // Leave Active to IDLE, then offer data while not accepting
        add(4'h0, 0, 0, 64'h0, 0, 1, 0, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0);
        add(4'h0, 1, 1, 64'hDEAD, 0, 0, 0, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 1, 0, 16'h0);
        add(4'h0, 1, 0, 64'hDEAD, 0, 0, 0, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0);
        add(4'h0, 1, 1, 64'hDEAD, 0, 0, 0, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 1, 0, 16'h0);
        add(4'h0, 1, 1, 64'hDEAD, 0, 0, 0, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 1, 0, 16'h0);
        add(4'h0, 0, 0, 64'h0, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].v, tbl[i].ir, tbl[i].d, tbl[i].rt);
            chk($sformatf("v%0d trdy", i), fdi_trdy, tbl[i].etrdy);
            chk($sformatf("v%0d ovf", i), overf, tbl[i].eovf);
            chk($sformatf("v%0d rvld", i), rdi_valid, tbl[i].evld);
            chk($sformatf("v%0d rirdy", i), rdi_irdy, tbl[i].evld);
            if (tbl[i].evld) chk($sformatf("v%0d rdata", i), r_data, tbl[i].edat);
        end

        // Drain: two entries queued, link leaves Active to a non-error state
        drive(4'h1, 0, 0, 64'h0, 0);
        drive(4'h1, 1, 1, entry(5), 0);
        chk("drain push0 trdy", fdi_trdy, 1);
        drive(4'h1, 1, 1, entry(6), 0);
        chk("drain push1 trdy", fdi_trdy, 1);
        drive(4'b0100, 0, 0, 64'h0, 0);
        got = 0;
        for (int c = 0; c < 20 && got < 8; c++) begin
            drive(4'b0100, 0, 0, 64'h0, 1);
            chk("drain trdy", fdi_trdy, 0);
            if (rdi_valid) begin
                chk($sformatf("drain beat%0d", got), r_data, ck(5 + got / 4, got % 4));
                got++;
            end
        end
        chk("drain beat count", got, 8);
        drive(4'b0100, 0, 0, 64'h0, 1);
        chk("drain done rvld", rdi_valid, 0);
        drive(4'b0100, 0, 0, 64'h0, 1);
        chk("drain to idle", 64'(dut.state_q), 0);

        // Flush mid-entry on LinkError, then resume with an empty FIFO
        drive(4'h1, 0, 0, 64'h0, 0);
        for (int k = 10; k < 13; k++) begin
            drive(4'h1, 1, 1, entry(k), 0);
            chk("flush push trdy", fdi_trdy, 1);
        end
        drive(4'h1, 0, 0, 64'h0, 1);
        chk("flush pre c0", r_data, ck(10, 0));
        drive(4'h1, 0, 0, 64'h0, 1);
        chk("flush pre c1", r_data, ck(10, 1));
        drive(4'b1010, 0, 0, 64'h0, 1);
        chk("flush pre c2 vld", rdi_valid, 1);
        drive(4'b1010, 0, 0, 64'h0, 1);
        chk("flush rvld", rdi_valid, 0);
        chk("flush trdy", fdi_trdy, 0);
        drive(4'b1010, 0, 0, 64'h0, 1);
        chk("flush rvld2", rdi_valid, 0);
        drive(4'h1, 0, 0, 64'h0, 1);
        drive(4'h1, 1, 1, entry(13), 1);
        chk("resume trdy", fdi_trdy, 1);
        drive(4'h1, 0, 0, 64'h0, 1);
        chk("resume empty", rdi_valid, 0);
        for (int c = 0; c < 4; c++) begin
            drive(4'h1, 0, 0, 64'h0, 1);
            chk($sformatf("resume vld%0d", c), rdi_valid, 1);
            chk($sformatf("resume c%0d", c), r_data, ck(13, c));
        end
        drive(4'h1, 0, 0, 64'h0, 1);
        chk("resume end rvld", rdi_valid, 0);

        // Asynchronous reset in the middle of a burst
        drive(4'h1, 1, 1, entry(1), 0);
        drive(4'h1, 1, 1, entry(2), 0);
        drive(4'h1, 0, 0, 64'h0, 0);
        chk("prerst rvld", rdi_valid, 1);
`ifdef UCIE_TX_OCCUPANCY_EN
        chk("prerst occ", occ, 2);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("arst trdy", fdi_trdy, 0);
        chk("arst ovf", overf, 0);
        chk("arst rvld", rdi_valid, 0);
        chk("arst rirdy", rdi_irdy, 0);
        chk("arst rdata", r_data, 0);
`ifdef UCIE_TX_OCCUPANCY_EN
        chk("arst occ", occ, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
